// File: rtl/num_editor_pkg.sv
// Shared constants and helpers for the num_editor digit-entry block.
package num_editor_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    localparam logic [3:0] HEX_MAX = 4'hF;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] digit_max(input logic bcd);
        return bcd ? BCD_MAX : HEX_MAX;
    endfunction

endpackage

// File: rtl/num_editor_btn_debounce.sv
// One push-button path: 2-flop synchroniser, stability counter, registered press pulse.
module btn_debounce #(
    parameter int DEB_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic press
);

    logic [1:0]       sync;
    logic [DEB_W-1:0] cnt;
    logic             stable_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= '0;
            cnt      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == {DEB_W{1'b1}}) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // Press fires on the rising edge of the debounced level only.
            stable_d <= stable;
            press    <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/num_editor.sv
// N-digit hex/BCD number editor driven by four debounced buttons and a one-hot cursor.
module num_editor
    import num_editor_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DEB_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            btn,
    input  logic                  bcd,
    input  logic                  carry_en,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   num,
    output logic [DIGITS-1:0]     cursor,
    output logic                  changed
);

    logic [3:0] stable, press, evt;

    for (genvar b = 0; b < 4; b++) begin : g_btn
        btn_debounce #(.DEB_W(DEB_W)) u_deb (
            .clk    (clk),
            .rst    (rst),
            .raw    (btn[b]),
            .stable (stable[b]),
            .press  (press[b])
        );
    end

    // The press pulse always coincides with a high debounced level.
    assign evt = press & stable;

    logic [3:0]          dmax;
    logic [4*DIGITS-1:0] num_up, num_dn;

    assign dmax = digit_max(bcd);

    // Ripple chain: a digit steps if it is the cursor or the digit below wrapped with carry enabled.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [3:0] d;
        logic       inc, dec;

        assign d = num[4*i +: 4];

        if (i == 0) begin : g_lsd
            assign inc = cursor[i];
            assign dec = cursor[i];
        end else begin : g_upper
            assign inc = cursor[i] | (carry_en & g_dig[i-1].inc & (g_dig[i-1].d >= dmax));
            assign dec = cursor[i] | (carry_en & g_dig[i-1].dec & (g_dig[i-1].d == 4'd0));
        end

        assign num_up[4*i +: 4] = !inc           ? d     :
                                  (d >= dmax)    ? 4'd0  : d + 4'd1;
        assign num_dn[4*i +: 4] = !dec           ? d     :
                                  (d == 4'd0)    ? dmax  :
                                  (d > dmax)     ? dmax  : d - 4'd1;
    end

    logic [4*DIGITS-1:0] num_n;
    logic [DIGITS-1:0]   cursor_n;
    logic                changed_n;

    always_comb begin
        num_n     = num;
        cursor_n  = cursor;
        changed_n = 1'b0;
        if (clr) begin
            num_n     = '0;
            cursor_n  = DIGITS'(1);
            changed_n = 1'b1;
        end else if (evt[BTN_UP]) begin
            num_n     = num_up;
            changed_n = 1'b1;
        end else if (evt[BTN_DOWN]) begin
            num_n     = num_dn;
            changed_n = 1'b1;
        end else if (evt[BTN_LEFT]) begin
            cursor_n  = (cursor << 1) | (cursor >> (DIGITS-1));
            changed_n = 1'b1;
        end else if (evt[BTN_RIGHT]) begin
            cursor_n  = (cursor >> 1) | (cursor << (DIGITS-1));
            changed_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num     <= '0;
            cursor  <= DIGITS'(1);
            changed <= 1'b0;
        end else begin
            num     <= num_n;
            cursor  <= cursor_n;
            changed <= changed_n;
        end
    end

endmodule

// File: tb/tb_num_editor.sv
// Directed bench for num_editor: vector table of button actions plus timing/reset sequences.
module tb_num_editor;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn;
    logic        bcd, carry_en, clr;
    logic [15:0] num;
    logic [3:0]  cursor;
    logic        changed;

    num_editor #(.DIGITS(4), .DEB_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .bcd      (bcd),
        .carry_en (carry_en),
        .clr      (clr),
        .num      (num),
        .cursor   (cursor),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int chg_cnt = 0;

    always @(negedge clk) if (changed === 1'b1) chg_cnt++;

    typedef struct {
        logic [3:0]  b;
        logic        bcd;
        logic        cen;
        logic        clr;
        logic [15:0] num;
        logic [3:0]  cur;
    } vec_t;

    vec_t vecs[$];

    localparam logic [3:0] U = 4'b0001, D = 4'b0010, L = 4'b0100, R = 4'b1000, N = 4'b0000;

    task automatic add(input logic [3:0] b, input logic bc, input logic ce, input logic cl,
                       input logic [15:0] n, input logic [3:0] c);
        vec_t v;
        v.b = b; v.bcd = bc; v.cen = ce; v.clr = cl; v.num = n; v.cur = c;
        vecs.push_back(v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] mask);
        btn = mask;
        tick(10);
        btn = 4'b0;
        tick(10);
    endtask

    initial begin
        int c0;
        rst = 1'b1; btn = 4'b0; bcd = 1'b0; carry_en = 1'b0; clr = 1'b0;
        tick(3);
        check("reset num", 32'(num), 32'h0);
        check("reset cursor", 32'(cursor), 32'h1);
        check("reset changed", 32'(changed), 32'h0);

        // Hold up from reset release: applied at edge 8, single pulse, no repeat.
        rst = 1'b0; btn = U; c0 = chg_cnt;
        tick(7);
        check("hold edge7 num", 32'(num), 32'h0);
        tick(1);
        check("hold edge8 num", 32'(num), 32'h1);
        check("hold edge8 changed", 32'(changed), 32'h1);
        tick(1);
        check("hold edge9 changed", 32'(changed), 32'h0);
        tick(8);
        check("hold no repeat num", 32'(num), 32'h1);
        check("hold change count", 32'(chg_cnt - c0), 32'd1);
        btn = 4'b0; tick(10);

        // Short glitches are rejected.
        clr = 1'b1; tick(1); clr = 1'b0; tick(2);
        c0 = chg_cnt;
        for (int w = 1; w <= 3; w++) begin
            btn = U; tick(w); btn = 4'b0; tick(8);
        end
        check("glitch num", 32'(num), 32'h0);
        check("glitch changes", 32'(chg_cnt - c0), 32'd0);

        add(N, 0, 0, 1, 16'h0000, 4'b0001);
        add(D, 0, 0, 0, 16'h000F, 4'b0001);
        add(L, 0, 0, 0, 16'h000F, 4'b0010);
        add(D, 0, 0, 0, 16'h00FF, 4'b0010);
        add(R, 0, 0, 0, 16'h00FF, 4'b0001);
        add(U, 0, 0, 0, 16'h00F0, 4'b0001);
        add(D, 0, 0, 1, 16'h000F, 4'b0001);
        add(D, 0, 1, 1, 16'hFFFF, 4'b0001);
        add(D, 1, 0, 1, 16'h0009, 4'b0001);
        add(L, 1, 0, 0, 16'h0009, 4'b0010);
        add(D, 1, 0, 0, 16'h0099, 4'b0010);
        add(R, 1, 0, 0, 16'h0099, 4'b0001);
        add(U, 1, 1, 0, 16'h0100, 4'b0001);
        add(D, 1, 0, 1, 16'h0009, 4'b0001);
        add(L, 1, 0, 0, 16'h0009, 4'b0010);
        add(D, 1, 0, 0, 16'h0099, 4'b0010);
        add(L, 1, 0, 0, 16'h0099, 4'b0100);
        add(D, 1, 0, 0, 16'h0999, 4'b0100);
        add(L, 1, 0, 0, 16'h0999, 4'b1000);
        add(D, 1, 0, 0, 16'h9999, 4'b1000);
        add(L, 1, 0, 0, 16'h9999, 4'b0001);
        add(U, 1, 1, 0, 16'h0000, 4'b0001);
        add(D, 0, 0, 1, 16'h000F, 4'b0001);
        add(D, 0, 0, 0, 16'h000E, 4'b0001);
        add(D, 0, 0, 0, 16'h000D, 4'b0001);
        add(D, 0, 0, 0, 16'h000C, 4'b0001);
        add(D, 1, 1, 0, 16'h0009, 4'b0001);
        add(R, 0, 0, 1, 16'h0000, 4'b1000);
        add(L, 0, 0, 0, 16'h0000, 4'b0001);
        add(L, 0, 0, 0, 16'h0000, 4'b0010);
        add(U, 0, 0, 0, 16'h0010, 4'b0010);
        add(U | D, 0, 0, 1, 16'h0001, 4'b0001);
        add(U | L, 0, 0, 0, 16'h0002, 4'b0001);

        foreach (vecs[k]) begin
            int exp_chg;
            bcd = vecs[k].bcd; carry_en = vecs[k].cen;
            c0 = chg_cnt;
            exp_chg = 0;
            if (vecs[k].clr) begin
                clr = 1'b1; tick(1); clr = 1'b0; tick(1);
                exp_chg++;
            end
            if (vecs[k].b != 4'b0) begin
                push(vecs[k].b);
                exp_chg++;
            end
            check($sformatf("vec%0d num", k), 32'(num), 32'(vecs[k].num));
            check($sformatf("vec%0d cursor", k), 32'(cursor), 32'(vecs[k].cur));
            check($sformatf("vec%0d changes", k), 32'(chg_cnt - c0), 32'(exp_chg));
        end

        // clr lands on the cycle the up event is applied; the up is dropped.
        bcd = 1'b0; carry_en = 1'b0;
        btn = U;
        tick(7);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr vs up num", 32'(num), 32'h0);
        check("clr vs up cursor", 32'(cursor), 32'h1);
        tick(10);
        check("clr vs up dropped", 32'(num), 32'h0);
        btn = 4'b0; tick(10);

        // Reset mid-debounce with button held.
        push(U);
        check("pre-reset num", 32'(num), 32'h1);
        btn = U;
        tick(2);
        rst = 1'b1;
        #1;
        check("rst async num", 32'(num), 32'h0);
        check("rst async cursor", 32'(cursor), 32'h1);
        check("rst async changed", 32'(changed), 32'h0);
        tick(3);
        rst = 1'b0;
        tick(7);
        check("post-rst edge7 num", 32'(num), 32'h0);
        tick(1);
        check("post-rst edge8 num", 32'(num), 32'h1);
        check("post-rst edge8 changed", 32'(changed), 32'h1);
        btn = 4'b0; tick(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
